// File: rtl/frequency_measurement_sequencer.sv
// Sequencer for the three-pixel frequency analyzer: clear, timed measurement window,
// then acknowledged readout of each action-time result into the AXI register file.
module frequency_measurement_sequencer #(
  parameter int WINDOW_CYCLES  = 1000000,
  parameter int CLEAR_CYCLES   = 4,
  parameter int RESULTS_NUMBER = 6,
  parameter int REGISTER_BASE  = 1,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_continuous,
  input  logic        cmd_abort,
  output logic        busy,
  output logic        analyzer_clear_n,
  output logic        analyzer_start,
  output logic        analyzer_stop,
  output logic [2:0]  result_index,
  input  logic [31:0] result_value,
  output logic [1:0]  register_operation,
  output logic [7:0]  register_number,
  output logic [31:0] register_write,
  input  logic        register_ack,
  output logic        irq,
  output logic        ack_error,
  output logic [15:0] measurement_count
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLEAR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(RESULTS_NUMBER - 1);
  localparam logic [7:0]       REG_BASE   = 8'(REGISTER_BASE);
  localparam logic [1:0]       OP_NONE    = 2'd0;
  localparam logic [1:0]       OP_WRITE   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_MEASURE,
    S_STOP,
    S_SELECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [CLR_W-1:0]  clear_cnt_reg;
  logic [WIN_W-1:0]  window_cnt_reg;
  logic [TO_W-1:0]   timeout_cnt_reg;
  logic [2:0]        idx_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      clear_cnt_reg      <= '0;
      window_cnt_reg     <= '0;
      timeout_cnt_reg    <= '0;
      idx_reg            <= '0;
      busy               <= 1'b0;
      analyzer_clear_n   <= 1'b1;
      analyzer_start     <= 1'b0;
      analyzer_stop      <= 1'b0;
      result_index       <= '0;
      register_operation <= OP_NONE;
      register_number    <= '0;
      register_write     <= '0;
      irq                <= 1'b0;
      ack_error          <= 1'b0;
      measurement_count  <= '0;
    end else begin
      analyzer_start <= 1'b0;
      analyzer_stop  <= 1'b0;
      irq            <= 1'b0;

      // Abort outranks everything, including an acknowledge arriving on the same edge.
      if (cmd_abort && (state_reg != S_IDLE)) begin
        state_reg          <= S_IDLE;
        busy               <= 1'b0;
        analyzer_clear_n   <= 1'b1;
        analyzer_stop      <= 1'b1;
        register_operation <= OP_NONE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (cmd_start) begin
              state_reg     <= S_CLEAR;
              busy          <= 1'b1;
              ack_error     <= 1'b0;
              clear_cnt_reg <= '0;
            end
          end

          S_CLEAR: begin
            analyzer_clear_n <= 1'b0;
            if (clear_cnt_reg == CLEAR_LAST) begin
              state_reg <= S_ARM;
            end else begin
              clear_cnt_reg <= clear_cnt_reg + CLR_W'(1);
            end
          end

          S_ARM: begin
            analyzer_clear_n <= 1'b1;
            analyzer_start   <= 1'b1;
            window_cnt_reg   <= '0;
            state_reg        <= S_MEASURE;
          end

          S_MEASURE: begin
            if (window_cnt_reg == WIN_LAST) begin
              state_reg <= S_STOP;
            end else begin
              window_cnt_reg <= window_cnt_reg + WIN_W'(1);
            end
          end

          S_STOP: begin
            analyzer_stop <= 1'b1;
            idx_reg       <= '0;
            result_index  <= '0;
            state_reg     <= S_SELECT;
          end

          // result_index has been stable for a full cycle, so result_value has settled.
          S_SELECT: begin
            register_operation <= OP_WRITE;
            register_number    <= REG_BASE + {5'd0, idx_reg};
            register_write     <= result_value;
            timeout_cnt_reg    <= '0;
            state_reg          <= S_WRITE;
          end

          S_WRITE: begin
            if (register_ack || (timeout_cnt_reg == TO_LAST)) begin
              register_operation <= OP_NONE;
              if (!register_ack) begin
                ack_error <= 1'b1;
              end
              if (idx_reg == IDX_LAST) begin
                state_reg <= S_DONE;
              end else begin
                idx_reg      <= idx_reg + 3'd1;
                result_index <= idx_reg + 3'd1;
                state_reg    <= S_SELECT;
              end
            end else begin
              timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
            end
          end

          S_DONE: begin
            irq               <= 1'b1;
            measurement_count <= measurement_count + 16'd1;
            if (cmd_continuous) begin
              state_reg     <= S_CLEAR;
              ack_error     <= 1'b0;
              clear_cnt_reg <= '0;
            end else begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
            end
          end

          default: begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frequency_measurement_sequencer.sv
// Randomized bench: an event monitor timestamps every pulse and write, and each run is
// compared against timings and data derived directly from the sequencing rules.
module tb_frequency_measurement_sequencer;

  localparam int WIN    = 16;
  localparam int CLR    = 4;
  localparam int RN     = 6;
  localparam int BASE   = 1;
  localparam int ACK_TO = 8;
  localparam int NEVER  = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_continuous = 1'b0;
  logic        cmd_abort = 1'b0;
  logic        busy;
  logic        analyzer_clear_n;
  logic        analyzer_start;
  logic        analyzer_stop;
  logic [2:0]  result_index;
  logic [31:0] result_value;
  logic [1:0]  register_operation;
  logic [7:0]  register_number;
  logic [31:0] register_write;
  logic        register_ack = 1'b0;
  logic        irq;
  logic        ack_error;
  logic [15:0] measurement_count;

  logic [31:0] vals [8];
  int          plan_delay [64];

  assign result_value = vals[result_index];

  frequency_measurement_sequencer #(
    .WINDOW_CYCLES  (WIN),
    .CLEAR_CYCLES   (CLR),
    .RESULTS_NUMBER (RN),
    .REGISTER_BASE  (BASE),
    .ACK_TIMEOUT    (ACK_TO)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .cmd_start          (cmd_start),
    .cmd_continuous     (cmd_continuous),
    .cmd_abort          (cmd_abort),
    .busy               (busy),
    .analyzer_clear_n   (analyzer_clear_n),
    .analyzer_start     (analyzer_start),
    .analyzer_stop      (analyzer_stop),
    .result_index       (result_index),
    .result_value       (result_value),
    .register_operation (register_operation),
    .register_number    (register_number),
    .register_write     (register_write),
    .register_ack       (register_ack),
    .irq                (irq),
    .ack_error          (ack_error),
    .measurement_count  (measurement_count)
  );

  initial forever #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  typedef struct {
    logic [7:0]  num;
    logic [31:0] data;
    int          begin_cyc;
    int          len;
    bit          stable;
  } wr_rec_t;

  wr_rec_t    wr_q[$];
  wr_rec_t    cur;
  int         clr_q[$];
  int         start_q[$];
  int         stop_q[$];
  int         irq_q[$];
  int         irqcnt_q[$];
  bit         irqerr_q[$];
  int         op_age = 0;
  int         wr_ord = 0;
  logic       prev_err = 1'b0;
  logic [1:0] prev_op = 2'd0;

  // Monitor plus register-file responder: acks write #wr_ord after plan_delay cycles.
  initial forever begin
    @(negedge clock);
    if (!analyzer_clear_n) clr_q.push_back(cyc);
    if (analyzer_start) start_q.push_back(cyc);
    if (analyzer_stop) stop_q.push_back(cyc);
    if (irq) begin
      irq_q.push_back(cyc);
      irqerr_q.push_back(prev_err);
      irqcnt_q.push_back(int'(measurement_count));
    end
    if (register_operation == 2'd2) begin
      if (prev_op != 2'd2) begin
        cur.num       = register_number;
        cur.data      = register_write;
        cur.begin_cyc = cyc;
        cur.len       = 0;
        cur.stable    = 1'b1;
      end
      cur.len++;
      if (register_number != cur.num || register_write != cur.data) cur.stable = 1'b0;
      op_age++;
    end else begin
      if (prev_op == 2'd2) begin
        wr_q.push_back(cur);
        wr_ord++;
      end
      op_age = 0;
    end
    prev_op  = register_operation;
    prev_err = ack_error;
    register_ack = (register_operation == 2'd2) && (op_age > plan_delay[wr_ord < 64 ? wr_ord : 63]);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int model_count = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic flush();
    clr_q.delete();
    start_q.delete();
    stop_q.delete();
    irq_q.delete();
    irqcnt_q.delete();
    irqerr_q.delete();
    wr_q.delete();
    wr_ord = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_clear_n"}, analyzer_clear_n, 1);
    check_eq({tag, "_start"}, analyzer_start, 0);
    check_eq({tag, "_stop"}, analyzer_stop, 0);
    check_eq({tag, "_result_index"}, result_index, 0);
    check_eq({tag, "_reg_op"}, register_operation, 0);
    check_eq({tag, "_reg_num"}, register_number, 0);
    check_eq({tag, "_reg_write"}, register_write, 0);
    check_eq({tag, "_irq"}, irq, 0);
    check_eq({tag, "_ack_error"}, ack_error, 0);
    check_eq({tag, "_count"}, measurement_count, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (busy) check_eq("wait_idle_timeout", busy, 0);
  endtask

  task automatic start_pulse(output int anchor);
    cmd_start = 1'b1;
    anchor = cyc + 1;
    @(negedge clock);
    cmd_start = 1'b0;
  endtask

  // Expected timeline of one run whose CLEAR state is entered on edge 'anchor'.
  task automatic verify_run(input int anchor, input int ord_base, output int irq_at);
    int t, d, len, v;
    bit err;
    wr_rec_t w;
    for (int k = 0; k < CLR; k++) begin
      v = -1;
      if (clr_q.size() > 0) v = clr_q.pop_front();
      check_eq("clear_n_low_cycle", v, anchor + 1 + k);
    end
    v = -1;
    if (start_q.size() > 0) v = start_q.pop_front();
    check_eq("start_pulse_cycle", v, anchor + CLR + 1);
    v = -1;
    if (stop_q.size() > 0) v = stop_q.pop_front();
    check_eq("stop_pulse_cycle", v, anchor + CLR + WIN + 2);
    t = anchor + CLR + WIN + 3;
    err = 1'b0;
    for (int i = 0; i < RN; i++) begin
      d = plan_delay[ord_base + i];
      len = (d < ACK_TO) ? d + 1 : ACK_TO;
      if (d >= ACK_TO) err = 1'b1;
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
      end else begin
        w.num = '0; w.data = '0; w.begin_cyc = -1; w.len = -1; w.stable = 1'b0;
      end
      $display("[TB] write %0d reg=%0d data=0x%08h begin=%0d cycles=%0d", i, w.num, w.data,
               w.begin_cyc, w.len);
      check_eq("write_reg_number", w.num, (BASE + i) % 256);
      check_eq("write_data", w.data, vals[i]);
      check_eq("write_begin_cycle", w.begin_cyc, t);
      check_eq("write_length", w.len, len);
      check_eq("write_stable", w.stable, 1);
      t = t + len + 1;
    end
    irq_at = t;
    v = -1;
    if (irq_q.size() > 0) v = irq_q.pop_front();
    check_eq("irq_cycle", v, irq_at);
    v = -1;
    if (irqerr_q.size() > 0) v = int'(irqerr_q.pop_front());
    check_eq("run_ack_error", v, int'(err));
    model_count = (model_count + 1) & 16'hFFFF;
    v = -1;
    if (irqcnt_q.size() > 0) v = irqcnt_q.pop_front();
    check_eq("count_at_irq", v, model_count);
  endtask

  task automatic check_leftover();
    check_eq("extra_events", clr_q.size() + start_q.size() + stop_q.size() + irq_q.size()
             + wr_q.size(), 0);
  endtask

  task automatic run_single(input bit poke);
    int a, irq_at;
    flush();
    start_pulse(a);
    check_eq("ack_error_cleared_on_start", ack_error, 0);
    if (poke) begin
      repeat (10) @(negedge clock);
      cmd_start = 1'b1;
      @(negedge clock);
      cmd_start = 1'b0;
    end
    wait_idle();
    verify_run(a, 0, irq_at);
    check_leftover();
    check_eq("busy_after_run", busy, 0);
    check_eq("count_after_run", measurement_count, model_count);
  endtask

  task automatic random_plan(input int n);
    for (int i = 0; i < n; i++)
      plan_delay[i] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 7));
  endtask

  task automatic random_vals();
    for (int i = 0; i < 8; i++) vals[i] = $urandom;
  endtask

  initial begin
    int a, n, irq1, irq2, irq3;
    for (int i = 0; i < 8; i++) vals[i] = 32'h100 + i;
    for (int i = 0; i < 64; i++) plan_delay[i] = 0;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    cmd_abort = 1'b1;
    @(negedge clock);
    cmd_abort = 1'b0;
    check_eq("idle_abort_stop", analyzer_stop, 0);
    check_eq("idle_abort_busy", busy, 0);

    // Immediate acknowledge, data 0x100+index.
    run_single(1'b0);

    // Acknowledge three cycles late; a stray cmd_start mid-run must be ignored.
    for (int i = 0; i < RN; i++) plan_delay[i] = 3;
    run_single(1'b1);

    // Result 2 never acknowledged.
    for (int i = 0; i < RN; i++) plan_delay[i] = 0;
    plan_delay[2] = NEVER;
    run_single(1'b0);
    check_eq("ack_error_sticky_idle", ack_error, 1);

    // Ack on the very cycle the timeout fires counts as an ack.
    for (int i = 0; i < RN; i++) plan_delay[i] = ACK_TO - 1;
    run_single(1'b0);

    // Three back-to-back continuous runs.
    random_vals();
    random_plan(3 * RN);
    flush();
    cmd_continuous = 1'b1;
    start_pulse(a);
    n = 0;
    while (irq_q.size() < 2 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check_eq("continuous_second_irq_seen", irq_q.size() >= 2, 1);
    cmd_continuous = 1'b0;
    wait_idle();
    verify_run(a, 0, irq1);
    verify_run(irq1, RN, irq2);
    verify_run(irq2, 2 * RN, irq3);
    check_leftover();
    check_eq("continuous_count", measurement_count, model_count);

    for (int r = 0; r < 4; r++) begin
      random_vals();
      random_plan(RN);
      run_single(r[0]);
    end

    // Abort while measuring.
    for (int i = 0; i < RN; i++) plan_delay[i] = 0;
    flush();
    start_pulse(a);
    n = 0;
    while (start_q.size() == 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_eq("abort_measure_started", start_q.size(), 1);
    repeat (5) @(negedge clock);
    cmd_abort = 1'b1;
    @(negedge clock);
    cmd_abort = 1'b0;
    check_eq("abort_measure_stop", analyzer_stop, 1);
    check_eq("abort_measure_op", register_operation, 0);
    check_eq("abort_measure_busy", busy, 0);
    check_eq("abort_measure_clear_n", analyzer_clear_n, 1);
    @(negedge clock);
    check_eq("abort_measure_stop_one_cycle", analyzer_stop, 0);
    repeat (40) @(negedge clock);
    check_eq("abort_measure_no_irq", irq_q.size(), 0);
    check_eq("abort_measure_stop_count", stop_q.size(), 1);
    check_eq("abort_measure_count", measurement_count, model_count);

    // Abort in WRITE on the same edge as register_ack.
    flush();
    start_pulse(a);
    n = 0;
    while (register_operation != 2'd2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_eq("abort_write_reached", register_operation, 2);
    cmd_abort = 1'b1;
    @(negedge clock);
    cmd_abort = 1'b0;
    check_eq("abort_write_op", register_operation, 0);
    check_eq("abort_write_stop", analyzer_stop, 1);
    check_eq("abort_write_busy", busy, 0);
    repeat (40) @(negedge clock);
    check_eq("abort_write_no_irq", irq_q.size(), 0);
    check_eq("abort_write_stop_count", stop_q.size(), 2);
    check_eq("abort_write_count", measurement_count, model_count);

    // Reset while measuring.
    flush();
    start_pulse(a);
    n = 0;
    while (start_q.size() == 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("reset_measure");
    model_count = 0;
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check_eq("reset_measure_no_stop", stop_q.size(), 0);
    check_eq("reset_measure_no_irq", irq_q.size(), 0);

    // Reset in WRITE after a timeout has set ack_error.
    plan_delay[0] = NEVER;
    flush();
    start_pulse(a);
    n = 0;
    while (!(wr_ord >= 1 && register_operation == 2'd2) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_eq("reset_write_reached", register_operation, 2);
    check_eq("reset_write_err_before", ack_error, 1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("reset_write");
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check_eq("reset_write_stop_count", stop_q.size(), 1);
    check_eq("reset_write_no_irq", irq_q.size(), 0);

    // Normal operation resumes with the counter restarted from zero.
    random_vals();
    random_plan(RN);
    run_single(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
